// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Multi-cycle control sequencer for the 8-bit CPU. It steps each instruction
// through FETCH -> DECODE -> EXECUTE -> (WRITEBACK) and drives the instruction
// memory handshake, IR load, ALU op, register write and PC increment/load.
// A FETCH that waits too long for memory sets a sticky fetch error and halts.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode halts the CPU and sets the sticky illegal_op
//   undefined : an illegal opcode executes as a NOP; illegal_op port is absent
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   run          1 = execute (sampled in IDLE and at instruction boundaries)
//   instr_valid  instruction memory data valid
//   opcode       IR opcode field
//   zero_flag    ALU zero flag, used by JZ in EXECUTE
//   instr_req    fetch request
//   ir_load      IR load strobe
//   alu_op       ALU operation (EXECUTE and WRITEBACK)
//   imm_sel      immediate into register-file write port (LDI)
//   reg_write    register-file write strobe
//   pc_en        PC increment strobe
//   pc_load      PC load strobe
//   halted       high in HALT
//   fetch_err    sticky fetch-timeout flag
//   illegal_op   sticky illegal-opcode flag (CTRL_ILLEGAL_TRAP_EN only)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for run
// S_FETCH  | requesting an instruction, timeout counter running
// S_DECODE | latching the opcode into op_q
// S_EXEC   | ALU op / branch / halt decision
// S_WB     | register write and PC increment
// S_HALT   | stopped; left only by reset
// -----------------------------------------------------------------------------
module control_fsm #(
   parameter int OPCODE_W  = 4,
   parameter int ALUOP_W   = 3,
   parameter int FETCH_TMO = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero_flag,
   output logic                instr_req,
   output logic                ir_load,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                imm_sel,
   output logic                reg_write,
   output logic                pc_en,
   output logic                pc_load,
   output logic                halted,
   output logic                fetch_err
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                illegal_op
`endif
);

   localparam int TMO_W = (FETCH_TMO > 1) ? $clog2(FETCH_TMO) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [TMO_W-1:0]    tmo_cnt_q;
   logic                fetch_err_q;

   logic [3:0] op_lo;
   logic       op_hi_nz;
   logic       is_alu, is_ldi, is_nop, is_jmp, is_jz, is_hlt, is_illegal;
   logic       tmo_hit;
   logic       boundary_run;

   assign op_lo    = op_q[3:0];
   assign op_hi_nz = ((op_q >> 4) != '0);

   assign is_alu     = !op_hi_nz && (op_lo >= 4'h1) && (op_lo <= 4'h8);
   assign is_ldi     = !op_hi_nz && (op_lo == 4'h9);
   assign is_nop     = !op_hi_nz && (op_lo == 4'h0);
   assign is_jmp     = !op_hi_nz && (op_lo == 4'hA);
   assign is_jz      = !op_hi_nz && (op_lo == 4'hB);
   assign is_hlt     = !op_hi_nz && (op_lo == 4'hF);
   assign is_illegal = op_hi_nz || (op_lo == 4'hC) || (op_lo == 4'hD) || (op_lo == 4'hE);

   // Counter holds the number of FETCH cycles already spent without data, so
   // the cycle where it equals FETCH_TMO-1 is the last one allowed.
   assign tmo_hit = (FETCH_TMO != 0) && !instr_valid &&
                    (tmo_cnt_q == TMO_W'(FETCH_TMO - 1));

   // Instruction boundary: the current instruction has completed.
   assign boundary_run = run;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH: begin
            if (instr_valid)  state_d = S_DECODE;
            else if (tmo_hit) state_d = S_HALT;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (is_alu || is_ldi)  state_d = S_WB;
            else if (is_hlt)       state_d = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            else if (is_illegal)   state_d = S_HALT;
`endif
            else                   state_d = boundary_run ? S_FETCH : S_IDLE;
         end
         S_WB:     state_d = boundary_run ? S_FETCH : S_IDLE;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_op_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         tmo_cnt_q   <= '0;
         fetch_err_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_op_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         // Any non-FETCH state zeroes the counter, which clears it on FETCH entry.
         if (state_q == S_FETCH && !instr_valid && FETCH_TMO != 0)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         else
            tmo_cnt_q <= '0;
         if (state_q == S_FETCH && tmo_hit) fetch_err_q <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
         if (state_q == S_EXEC && is_illegal) illegal_op_q <= 1'b1;
`endif
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal_op = illegal_op_q;
`endif

   // Outputs are decoded from the registered state so that an async reset
   // clears every strobe immediately. Only ir_load (instr_valid) and the
   // JZ choice (zero_flag) look at inputs; run never reaches an output.
   always_comb begin
      instr_req = 1'b0;
      ir_load   = 1'b0;
      alu_op    = '0;
      imm_sel   = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      pc_load   = 1'b0;
      halted    = 1'b0;
      fetch_err = fetch_err_q;
      case (state_q)
         S_FETCH: begin
            instr_req = 1'b1;
            ir_load   = instr_valid;
         end
         S_EXEC: begin
            if (is_alu) alu_op = ALUOP_W'(op_lo - 4'd1);
            imm_sel = is_ldi;
            pc_load = is_jmp || (is_jz && zero_flag);
`ifdef CTRL_ILLEGAL_TRAP_EN
            pc_en   = is_nop || (is_jz && !zero_flag);
`else
            pc_en   = is_nop || (is_jz && !zero_flag) || is_illegal;
`endif
         end
         S_WB: begin
            if (is_alu) alu_op = ALUOP_W'(op_lo - 4'd1);
            imm_sel   = is_ldi;
            reg_write = 1'b1;
            pc_en     = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       instr_valid;
   logic [3:0] opcode;
   logic       zero_flag;
   logic       instr_req, ir_load, imm_sel, reg_write, pc_en, pc_load, halted, fetch_err;
   logic [2:0] alu_op;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   control_fsm #(.OPCODE_W(4), .ALUOP_W(3), .FETCH_TMO(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .instr_valid (instr_valid),
      .opcode      (opcode),
      .zero_flag   (zero_flag),
      .instr_req   (instr_req),
      .ir_load     (ir_load),
      .alu_op      (alu_op),
      .imm_sel     (imm_sel),
      .reg_write   (reg_write),
      .pc_en       (pc_en),
      .pc_load     (pc_load),
      .halted      (halted),
      .fetch_err   (fetch_err)
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,
      .illegal_op  (illegal_op)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Ends on a negedge with rst just released; DUT is in IDLE.
   task automatic do_reset();
      rst = 1'b1; run = 1'b0; instr_valid = 1'b0; opcode = 4'h0; zero_flag = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] op;
      logic       zf;
      logic [2:0] alu;
      logic       imm;
      logic       pcen;
      logic       pcld;
      logic       wb;
      logic       halt;
      logic       ill;
   } vec_t;

   vec_t vt[12];

   initial begin
      int hits;
      // op, zf, alu, imm, pc_en(EX), pc_load(EX), wb, halt, illegal
      vt[0]  = '{4'h1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{4'h2, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{4'h5, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{4'h8, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{4'h9, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{4'hA, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{4'hB, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{4'hB, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef CTRL_ILLEGAL_TRAP_EN
      vt[10] = '{4'hD, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[11] = '{4'hE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
      vt[10] = '{4'hD, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[11] = '{4'hE, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

      // Reset state, before any clock edge
      rst = 1'b1; run = 1'b1; instr_valid = 1'b1; opcode = 4'h1; zero_flag = 1'b0;
      #1;
      chk("rst_outputs", {instr_req, ir_load, alu_op, imm_sel, reg_write, pc_en, pc_load, halted, fetch_err}, '0);

      // Table-driven instruction vectors, valid in first FETCH cycle
      for (int i = 0; i < 12; i++) begin
         do_reset();
         run = 1'b1;
         #1 chk($sformatf("v%0d_idle_req", i), instr_req, 1'b0);
         @(negedge clk);                          // c0 FETCH
         instr_valid = 1'b1; opcode = vt[i].op;
         #1 chk($sformatf("v%0d_c0_req_load", i), {instr_req, ir_load}, 2'b11);
         @(negedge clk);                          // c1 DECODE
         instr_valid = 1'b0;
         #1 chk($sformatf("v%0d_c1_quiet", i), {instr_req, reg_write, pc_en, pc_load}, 4'b0);
         @(negedge clk);                          // c2 EXECUTE
         zero_flag = vt[i].zf;
         #1 chk($sformatf("v%0d_c2_exec", i), {alu_op, imm_sel, pc_en, pc_load, reg_write},
                {vt[i].alu, vt[i].imm, vt[i].pcen, vt[i].pcld, 1'b0});
         @(negedge clk);                          // c3
         #1;
         if (vt[i].wb) begin
            chk($sformatf("v%0d_c3_wb", i), {alu_op, imm_sel, reg_write, pc_en, pc_load},
                {vt[i].alu, vt[i].imm, 1'b1, 1'b1, 1'b0});
            @(negedge clk);                       // c4 next FETCH
            #1 chk($sformatf("v%0d_c4_req", i), instr_req, 1'b1);
         end else begin
            chk($sformatf("v%0d_c3_next", i), {instr_req, halted}, {~vt[i].halt, vt[i].halt});
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         chk($sformatf("v%0d_illegal_op", i), illegal_op, vt[i].ill);
`endif
      end

      // Async reset in the middle of an ADD writeback
      do_reset();
      run = 1'b1;
      @(negedge clk); instr_valid = 1'b1; opcode = 4'h1;
      @(negedge clk); instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 chk("wb_before_rst", {reg_write, pc_en}, 2'b11);
      #2 rst = 1'b1;
      #1 chk("wb_async_rst", {reg_write, pc_en, halted, instr_req}, 4'b0);
      @(negedge clk); rst = 1'b0; run = 1'b0;
      @(negedge clk);
      #1 chk("after_rst_idle", {instr_req, reg_write, pc_en, pc_load}, 4'b0);

      // Fetch timeout: 15 FETCH cycles without instr_valid
      do_reset();
      run = 1'b1;
      hits = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         #1 if (!instr_req || fetch_err || halted) hits++;
      end
      chk("tmo_wait_clean", hits, 0);
      @(negedge clk);
      #1 chk("tmo_err_halt", {fetch_err, halted, instr_req}, 3'b110);

      // Halted with run=1 for 20 cycles: no fetch
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1 if (instr_req || !halted) hits++;
      end
      chk("halt_stuck", hits, 0);

      // Valid arriving in FETCH cycle 15 wins over the timeout
      do_reset();
      run = 1'b1;
      for (int k = 1; k <= 14; k++) @(negedge clk);
      @(negedge clk);
      instr_valid = 1'b1; opcode = 4'h0;
      #1 chk("tmo15_load", ir_load, 1'b1);
      @(negedge clk); instr_valid = 1'b0;
      #1 chk("tmo15_no_err", {fetch_err, halted}, 2'b00);
      @(negedge clk);
      #1 chk("tmo15_nop_exec", {pc_en, fetch_err}, 2'b10);

      // run dropped during EXECUTE of SUB: WB completes, then IDLE
      do_reset();
      run = 1'b1;
      @(negedge clk); instr_valid = 1'b1; opcode = 4'h2;
      @(negedge clk); instr_valid = 1'b0;
      @(negedge clk); run = 1'b0;
      #1 chk("rundrop_exec_alu", alu_op, 3'd1);
      @(negedge clk);
      #1 chk("rundrop_wb", {reg_write, pc_en}, 2'b11);
      @(negedge clk);
      #1 chk("rundrop_idle1", instr_req, 1'b0);
      @(negedge clk);
      #1 chk("rundrop_idle2", instr_req, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
